the_demux_switch_1: RTL

Write-side counterpart of the four-register source mux: takes a value from the shared 8-bit data bus and writes it, or a derived value, into one of registers R0–R3, selected by the same two select lines `I11`/`I10`. Commands arrive over a valid/ready handshake and run through a three-state FSM. The four register outputs feed the read-side mux directly.

---
 rtl/cpu_reg_pkg.sv | 33 +++
 rtl/the_dec_2to4.sv | 33 +++
 rtl/the_demux_switch_1.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cpu_reg_pkg.sv
// ============================================================================
//  Module      : cpu_reg_pkg
//  Description : Shared constants for the register write path: operation
//                codes, write-FSM state encoding and register indices.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_reg_pkg;

    // Number of destination registers addressed by the two select lines
    localparam int NUM_REGS = 4;

    // Operation codes carried on the op input
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_CLR  = 2'd1;
    localparam logic [1:0] OP_INC  = 2'd2;
    localparam logic [1:0] OP_DEC  = 2'd3;

    // Write FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Register index constants, matching {I11,I10}
    localparam logic [1:0] R0_IDX = 2'd0;
    localparam logic [1:0] R1_IDX = 2'd1;
    localparam logic [1:0] R2_IDX = 2'd2;
    localparam logic [1:0] R3_IDX = 2'd3;

endpackage

`default_nettype wire

// File: rtl/the_dec_2to4.sv
// ============================================================================
//  Module      : the_dec_2to4
//  Description : Combinational 2-to-4 one-hot decoder with enable. Produces
//                the per-register write enables from the latched select.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module the_dec_2to4
    import cpu_reg_pkg::*;
(
    input  logic [1:0]          sel_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    // One-hot decode of the select, forced to zero when not enabled
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            case (sel_i)
                R0_IDX:  onehot_o = 4'b0001;
                R1_IDX:  onehot_o = 4'b0010;
                R2_IDX:  onehot_o = 4'b0100;
                R3_IDX:  onehot_o = 4'b1000;
                default: onehot_o = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/the_demux_switch_1.sv
// ============================================================================
//  Module      : the_demux_switch_1
//  Description : Write-side register demux. Accepts a command over a
//                valid/ready handshake, then loads, clears, increments or
//                decrements one of R0-R3 through an IDLE/EXEC/DONE FSM.
//                Reports wrap-around of INC/DEC on a sticky flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module the_demux_switch_1
    import cpu_reg_pkg::*;
#(
    parameter int                 DATA_W  = 8,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              I11,
    input  logic              I10,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] input_x,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              wr_done,
    output logic              wrap,
    output logic [DATA_W-1:0] output_R0,
    output logic [DATA_W-1:0] output_R1,
    output logic [DATA_W-1:0] output_R2,
    output logic [DATA_W-1:0] output_R3
);

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [1:0]          sel_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic                wrap_q;
    logic                wrap_d;
    logic [DATA_W-1:0]   cur_val;
    logic [DATA_W-1:0]   result_d;
    logic [NUM_REGS-1:0] reg_we;
    logic                accept;
    logic                in_exec;

    assign accept  = (state_q == ST_IDLE) && wr_valid;
    assign in_exec = (state_q == ST_EXEC);

    // Next-state logic: one command takes exactly three cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (wr_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch: everything is captured at acceptance so later input
    // changes cannot disturb a command in flight
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sel_q  <= R0_IDX;
            op_q   <= OP_LOAD;
            data_q <= '0;
        end else if (accept) begin
            sel_q  <= {I11, I10};
            op_q   <= op;
            data_q <= input_x;
        end
    end

    // Result and wrap detection for the selected register
    always_comb begin
        cur_val  = regs_q[sel_q];
        result_d = cur_val;
        wrap_d   = 1'b0;
        case (op_q)
            OP_LOAD: result_d = data_q;
            OP_CLR:  result_d = '0;
            OP_INC: begin
                result_d = cur_val + DATA_W'(1);
                wrap_d   = (cur_val == {DATA_W{1'b1}});
            end
            OP_DEC: begin
                result_d = cur_val - DATA_W'(1);
                wrap_d   = (cur_val == '0);
            end
            default: result_d = cur_val;
        endcase
    end

    // Per-register write enables, only active during EXEC
    the_dec_2to4 u_dec (
        .sel_i    (sel_q),
        .en_i     (in_exec),
        .onehot_o (reg_we)
    );

    // Register bank: only the decoded register takes the result
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_we[i]) begin
                    regs_q[i] <= result_d;
                end
            end
        end
    end

    // Sticky wrap flag: rewritten by every executed command, held otherwise
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wrap_q <= 1'b0;
        end else if (in_exec) begin
            wrap_q <= wrap_d;
        end
    end

    // Handshake outputs decode state only; ready is held low while in reset
    assign wr_ready  = (state_q == ST_IDLE) && sys_rst;
    assign wr_done   = (state_q == ST_DONE);
    assign wrap      = wrap_q;
    assign output_R0 = regs_q[0];
    assign output_R1 = regs_q[1];
    assign output_R2 = regs_q[2];
    assign output_R3 = regs_q[3];

endmodule

`default_nettype wire
